// File: rtl/dp_ram_init.sv
// Simple dual-port RAM with a reset-time init sequencer, read-valid tracking,
// optional output register and selectable read-during-write behaviour.
module dp_ram_init #(
    parameter int unsigned DWIDTH    = 16,
    parameter int unsigned AWIDTH    = 9,
    parameter int unsigned DEPTH     = 2 ** AWIDTH,
    parameter int unsigned OUTREG    = 0,
    parameter int unsigned RDW_NEW   = 0,
    parameter int unsigned INIT_RAMP = 0,
    parameter int unsigned INIT_BASE = 0
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] wrdata_i,
    input  logic [AWIDTH-1:0] wraddr_i,
    input  logic              wren_i,
    input  logic [AWIDTH-1:0] rdaddr_i,
    input  logic              rden_i,
    output logic [DWIDTH-1:0] rddata_o,
    output logic              rdvalid_o,
    output logic              init_done_o
);

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic              state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    logic              run;
    logic              cnt_last;
    logic              wr_in_range, rd_in_range;
    logic              user_wr, rd_fire;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_waddr;
    logic [DWIDTH-1:0] mem_wdata, init_word;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [DWIDTH-1:0] rd_mem_q;
    logic [DWIDTH-1:0] byp_data_q;
    logic              rd_vld_q, rd_zero_q, rd_byp_q;
    logic [DWIDTH-1:0] rd_data;

    assign run         = (state_q == ST_RUN);
    assign cnt_last    = (32'(cnt_q) == DEPTH - 1);
    assign wr_in_range = (32'(wraddr_i) < DEPTH);
    assign rd_in_range = (32'(rdaddr_i) < DEPTH);
    assign user_wr     = run && wren_i && wr_in_range;
    assign rd_fire     = run && rden_i;
    assign init_word   = (INIT_RAMP != 0) ? DWIDTH'(INIT_BASE + 32'(cnt_q)) : '0;

    // The init sequencer owns the single write port until RUN.
    assign mem_we    = !srst_i && (!run || user_wr);
    assign mem_waddr = run ? wraddr_i : cnt_q;
    assign mem_wdata = run ? wrdata_i : init_word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!run) begin
            cnt_d = cnt_q + AWIDTH'(1);
            if (cnt_last) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_done_o = run;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // No reset on the array read register so it stays inside the block RAM.
    always_ff @(posedge clk_i) begin
        if (rd_fire && rd_in_range) begin
            rd_mem_q <= mem[rdaddr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            rd_vld_q   <= 1'b0;
            rd_zero_q  <= 1'b1;
            rd_byp_q   <= 1'b0;
            byp_data_q <= '0;
        end else begin
            rd_vld_q <= rd_fire;
            if (rd_fire) begin
                rd_zero_q  <= !rd_in_range;
                rd_byp_q   <= (RDW_NEW != 0) && user_wr && (wraddr_i == rdaddr_i);
                byp_data_q <= wrdata_i;
            end
        end
    end

    // rd_zero_q forces 0 both after reset and for out-of-range reads.
    assign rd_data = rd_zero_q ? '0 : (rd_byp_q ? byp_data_q : rd_mem_q);

    if (OUTREG != 0) begin : g_outreg
        logic [DWIDTH-1:0] out_q;
        logic              out_vld_q;

        always_ff @(posedge clk_i) begin
            if (srst_i) begin
                out_q     <= '0;
                out_vld_q <= 1'b0;
            end else begin
                out_vld_q <= rd_vld_q;
                if (rd_vld_q) begin
                    out_q <= rd_data;
                end
            end
        end

        assign rddata_o  = out_q;
        assign rdvalid_o = out_vld_q;
    end else begin : g_noreg
        assign rddata_o  = rd_data;
        assign rdvalid_o = rd_vld_q;
    end

endmodule

// File: tb/tb_dp_ram_init.sv
// Directed bench for dp_ram_init: four instances with different parameter sets
// share one stimulus stream; each output is checked against hand-built values.
module tb_dp_ram_init;

    logic        clk = 1'b0;
    logic        srst, wren, rden;
    logic [15:0] wrdata;
    logic [3:0]  wraddr, rdaddr;

    logic [7:0]  a_data;
    logic [15:0] b_data, c_data;
    logic [3:0]  d_data;
    logic        a_vld, b_vld, c_vld, d_vld;
    logic        a_done, b_done, c_done, d_done;

    int tests = 0;
    int fails = 0;

    logic [15:0] ma [16];
    logic [15:0] mb [16];
    logic [15:0] mc [16];
    logic [3:0]  md [4];

    always #5 clk = ~clk;

    // A: ramp from 0xa0, latency 1, old-data read-during-write
    dp_ram_init #(.DWIDTH(8), .AWIDTH(4), .DEPTH(16), .OUTREG(0), .RDW_NEW(0),
                  .INIT_RAMP(1), .INIT_BASE(8'ha0)) u_a (
        .clk_i(clk), .srst_i(srst), .wrdata_i(wrdata[7:0]), .wraddr_i(wraddr),
        .wren_i(wren), .rdaddr_i(rdaddr), .rden_i(rden), .rddata_o(a_data),
        .rdvalid_o(a_vld), .init_done_o(a_done));

    // B: 12 words, zero init, latency 2
    dp_ram_init #(.DWIDTH(16), .AWIDTH(4), .DEPTH(12), .OUTREG(1), .RDW_NEW(0),
                  .INIT_RAMP(0), .INIT_BASE(0)) u_b (
        .clk_i(clk), .srst_i(srst), .wrdata_i(wrdata), .wraddr_i(wraddr),
        .wren_i(wren), .rdaddr_i(rdaddr), .rden_i(rden), .rddata_o(b_data),
        .rdvalid_o(b_vld), .init_done_o(b_done));

    // C: zero init, new-data bypass
    dp_ram_init #(.DWIDTH(16), .AWIDTH(4), .DEPTH(16), .OUTREG(0), .RDW_NEW(1),
                  .INIT_RAMP(0), .INIT_BASE(0)) u_c (
        .clk_i(clk), .srst_i(srst), .wrdata_i(wrdata), .wraddr_i(wraddr),
        .wren_i(wren), .rdaddr_i(rdaddr), .rden_i(rden), .rddata_o(c_data),
        .rdvalid_o(c_vld), .init_done_o(c_done));

    // D: 4-bit ramp starting at 14, wraps
    dp_ram_init #(.DWIDTH(4), .AWIDTH(2), .DEPTH(4), .OUTREG(0), .RDW_NEW(0),
                  .INIT_RAMP(1), .INIT_BASE(14)) u_d (
        .clk_i(clk), .srst_i(srst), .wrdata_i(wrdata[3:0]), .wraddr_i(wraddr[1:0]),
        .wren_i(wren), .rdaddr_i(rdaddr[1:0]), .rden_i(rden), .rddata_o(d_data),
        .rdvalid_o(d_vld), .init_done_o(d_done));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic init_model();
        for (int a = 0; a < 16; a++) begin
            ma[a] = 16'(8'ha0 + a);
            mb[a] = 16'h0;
            mc[a] = 16'h0;
        end
        md[0] = 4'he;
        md[1] = 4'hf;
        md[2] = 4'h0;
        md[3] = 4'h1;
    endtask

    // Back-to-back reads of 0..n-1; called just after a falling edge.
    task automatic sweep(input int n);
        for (int i = 0; i <= n + 1; i++) begin
            if (i >= 1 && i <= n) begin
                check($sformatf("a_vld[%0d]", i - 1), 32'(a_vld), 1);
                check($sformatf("a_rd[%0d]", i - 1), 32'(a_data), 32'(ma[i - 1]));
                check($sformatf("c_rd[%0d]", i - 1), 32'(c_data), 32'(mc[i - 1]));
                check($sformatf("d_vld[%0d]", i - 1), 32'(d_vld), 1);
                check($sformatf("d_rd[%0d]", i - 1), 32'(d_data), 32'(md[(i - 1) % 4]));
            end
            if (i == n + 1) begin
                check("a_vld_after", 32'(a_vld), 0);
            end
            if (i >= 2) begin
                check($sformatf("b_vld[%0d]", i - 2), 32'(b_vld), 1);
                check($sformatf("b_rd[%0d]", i - 2), 32'(b_data), 32'(mb[i - 2]));
            end
            if (i < n) begin
                rden   = 1'b1;
                rdaddr = 4'(i);
            end else begin
                rden = 1'b0;
            end
            @(negedge clk);
        end
        check("b_vld_after", 32'(b_vld), 0);
    endtask

    initial begin
        srst   = 1'b1;
        wren   = 1'b0;
        rden   = 1'b0;
        wrdata = '0;
        wraddr = '0;
        rdaddr = '0;
        repeat (3) @(negedge clk);
        check("rst_a_data", 32'(a_data), 0);
        check("rst_a_vld", 32'(a_vld), 0);
        check("rst_a_done", 32'(a_done), 0);
        check("rst_b_vld", 32'(b_vld), 0);
        check("rst_d_done", 32'(d_done), 0);

        // Init run; user write/read attempts during INIT must be ignored.
        srst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) begin
                wren = 1'b1; rden = 1'b1; wraddr = 4'd0; rdaddr = 4'd0; wrdata = 16'h5555;
            end
            if (k == 3) begin
                wren = 1'b0; rden = 1'b0;
            end
            if (k >= 2 && k <= 5) begin
                check($sformatf("init_a_vld[%0d]", k), 32'(a_vld), 0);
                check($sformatf("init_b_vld[%0d]", k), 32'(b_vld), 0);
                check($sformatf("init_d_vld[%0d]", k), 32'(d_vld), 0);
            end
            if (k == 3)  check("d_done_k3", 32'(d_done), 0);
            if (k == 4)  check("d_done_k4", 32'(d_done), 1);
            if (k == 11) check("b_done_k11", 32'(b_done), 0);
            if (k == 12) check("b_done_k12", 32'(b_done), 1);
            if (k == 15) check("a_done_k15", 32'(a_done), 0);
            if (k == 16) begin
                check("a_done_k16", 32'(a_done), 1);
                check("c_done_k16", 32'(c_done), 1);
            end
        end
        init_model();
        sweep(16);

        // Single read pulse latency.
        rden = 1'b1; rdaddr = 4'd5;
        @(negedge clk);
        rden = 1'b0;
        check("pulse_a_vld1", 32'(a_vld), 1);
        check("pulse_a_data", 32'(a_data), 32'h a5);
        check("pulse_b_vld1", 32'(b_vld), 0);
        @(negedge clk);
        check("pulse_a_vld2", 32'(a_vld), 0);
        check("pulse_a_hold", 32'(a_data), 32'h a5);
        check("pulse_b_vld2", 32'(b_vld), 1);
        @(negedge clk);
        check("pulse_b_vld3", 32'(b_vld), 0);

        // Same-address read during write.
        wren = 1'b1; wraddr = 4'd3; wrdata = 16'h1234; rden = 1'b1; rdaddr = 4'd3;
        @(negedge clk);
        wren = 1'b0;
        check("rdw_a_old", 32'(a_data), 32'h a3);
        check("rdw_c_new", 32'(c_data), 32'h1234);
        check("rdw_d_old", 32'(d_data), 32'h1);
        @(negedge clk);
        rden = 1'b0;
        check("rdw_a_next", 32'(a_data), 32'h34);
        check("rdw_c_next", 32'(c_data), 32'h1234);
        check("rdw_d_next", 32'(d_data), 32'h4);
        check("rdw_b_vld", 32'(b_vld), 1);
        check("rdw_b_old", 32'(b_data), 32'h0);
        @(negedge clk);
        check("rdw_b_next", 32'(b_data), 32'h1234);
        ma[3] = 16'h34;
        mb[3] = 16'h1234;
        mc[3] = 16'h1234;
        md[3] = 4'h4;

        // Write to address 13: dropped by the 12-word instance only.
        wren = 1'b1; wraddr = 4'd13; wrdata = 16'hffff;
        @(negedge clk);
        wren = 1'b0;
        ma[13] = 16'hff;
        mc[13] = 16'hffff;
        md[1]  = 4'hf;
        sweep(16);

        // Reset in RUN clears outputs.
        srst = 1'b1;
        @(negedge clk);
        check("srun_a_data", 32'(a_data), 0);
        check("srun_a_vld", 32'(a_vld), 0);
        check("srun_a_done", 32'(a_done), 0);
        check("srun_d_data", 32'(d_data), 0);
        srst = 1'b0;

        // Reset again at INIT cycle 7; init must restart from scratch.
        repeat (7) @(negedge clk);
        check("mid_a_done7", 32'(a_done), 0);
        srst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_a_done_rst", 32'(a_done), 0);
        srst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 4)  check("re_d_done_k4", 32'(d_done), 1);
            if (k == 15) check("re_a_done_k15", 32'(a_done), 0);
            if (k == 16) check("re_a_done_k16", 32'(a_done), 1);
        end
        init_model();
        sweep(16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
